// File: rtl/jtdd_dwnld_ctrl.sv
// ----------------------------------------------------------------------------
// jtdd_dwnld_ctrl
//
// ROM-download router. Takes the byte stream from the ioctl loader and turns
// it into 16-bit SDRAM word writes. A parameter table of up to eight regions
// decides where each byte lands. Each region has a byte start address, an
// SDRAM word base, and an address swizzle mode (LIN / CHR / TILE). In LIN
// regions an even byte and the odd byte that follows it are merged into one
// full-word write. SDRAM writes pass through a 2-entry FIFO so the SDRAM side
// can stall with prog_rdy. Bytes at or above PROM_START skip the FIFO and go
// out as one-cycle PROM write strobes.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   downloading    download window; bytes are only accepted while high
//   ioctl_addr     byte address of the incoming byte
//   ioctl_data     incoming byte
//   ioctl_wr       one-cycle byte strobe
//   prog_addr      SDRAM word address of the FIFO head
//   prog_data      {high byte, low byte}; a single byte appears in both halves
//   prog_mask      active-low byte enables, bit0 = low byte
//   prog_we        FIFO non-empty; the head stays put until prog_rdy
//   prog_rdy       SDRAM took the head word
//   prom_we        one-hot PROM write strobe, one cycle per PROM byte
//   prom_addr      PROM byte address
//   prom_data      PROM byte data
//   dwnld_busy     download window open, FIFO non-empty or even byte waiting
//   overflow       sticky: a word was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module jtdd_dwnld_ctrl #(
  parameter int              AW         = 22,
  parameter int              NREG       = 6,
  parameter logic [8*AW-1:0] REG_START  = '0,
  parameter logic [8*AW-1:0] REG_BASE   = '0,
  parameter logic [15:0]     REG_MODE   = '0,
  parameter logic [39:0]     REG_HBIT   = {8{5'd16}},
  parameter logic [AW-1:0]   PROM_START = 22'h124000,
  parameter int              PW         = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          downloading,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [7:0]    ioctl_data,
  input  logic          ioctl_wr,
  output logic [AW-1:0] prog_addr,
  output logic [15:0]   prog_data,
  output logic [1:0]    prog_mask,
  output logic          prog_we,
  input  logic          prog_rdy,
  output logic [PW-1:0] prom_we,
  output logic [7:0]    prom_addr,
  output logic [7:0]    prom_data,
  output logic          dwnld_busy,
  output logic          overflow
);

  typedef enum logic [1:0] {
    MODE_LIN  = 2'd0,
    MODE_CHR  = 2'd1,
    MODE_TILE = 2'd2
  } mode_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    mask;
  } word_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic          dl_q,        dl_d;
  logic          pend_v_q,    pend_v_d;
  logic [AW-1:0] pend_word_q, pend_word_d;   // SDRAM word of the held byte
  logic [AW-1:0] pend_addr_q, pend_addr_d;   // ioctl byte address of it
  logic [7:0]    pend_byte_q, pend_byte_d;
  logic [2:0]    pend_reg_q,  pend_reg_d;
  word_t         slot0_q,     slot0_d;       // FIFO head
  word_t         slot1_q,     slot1_d;
  logic [1:0]    cnt_q,       cnt_d;
  logic          ovf_q,       ovf_d;
  logic [PW-1:0] prom_we_q,   prom_we_d;
  logic [7:0]    prom_addr_q, prom_addr_d;
  logic [7:0]    prom_data_q, prom_data_d;

  // --------------------------------------------------------------------------
  // Input qualification and download-window edges
  // --------------------------------------------------------------------------
  logic wr_acc;
  logic dl_fall;
  logic dl_rise;

  assign wr_acc  = downloading & ioctl_wr;
  assign dl_fall = dl_q & ~downloading;
  assign dl_rise = ~dl_q & downloading;
  assign dl_d    = downloading;

  // --------------------------------------------------------------------------
  // Region lookup: the highest used entry whose start is not above the byte
  // --------------------------------------------------------------------------
  logic          reg_hit;
  logic [2:0]    reg_sel;
  logic [AW-1:0] sel_start;
  logic [AW-1:0] sel_base;
  logic [1:0]    sel_mode;
  logic [4:0]    sel_hbit;
  logic [AW-1:0] off;

  // NOTE: every always_comb output gets a default before any branch, otherwise
  // a path that skips the assignment leaves a latch behind.
  always_comb begin
    reg_hit = 1'b0;
    reg_sel = '0;
    for (int i = 0; i < NREG; i++) begin
      if (ioctl_addr >= REG_START[i*AW +: AW]) begin
        reg_hit = 1'b1;
        reg_sel = 3'(i);
      end
    end
  end

  assign sel_start = REG_START[int'(reg_sel)*AW +: AW];
  assign sel_base  = REG_BASE[int'(reg_sel)*AW +: AW];
  assign sel_mode  = REG_MODE[int'(reg_sel)*2 +: 2];
  assign sel_hbit  = REG_HBIT[int'(reg_sel)*5 +: 5];
  assign off       = ioctl_addr - sel_start;

  // --------------------------------------------------------------------------
  // Word address per mode; all sums wrap at AW bits
  // --------------------------------------------------------------------------
  logic [AW-1:0] lin_word;
  logic [AW-1:0] chr_word;
  logic [AW-1:0] tile_word;
  logic [AW-1:0] tile_bit;
  logic [AW-1:0] tile_o;
  logic          tile_top;

  assign lin_word  = sel_base + (off >> 1);
  // CHR moves offset bit 4 down to bit 0 and bit 3 becomes the byte lane.
  assign chr_word  = sel_base + {1'b0, off[AW-1:5], off[2:0], off[4]};
  // TILE: bit HBIT picks the byte lane and is removed from the address.
  assign tile_bit  = AW'(1) << sel_hbit;
  assign tile_top  = |(off & tile_bit);
  assign tile_o    = off & ~tile_bit;
  assign tile_word = sel_base + {tile_o[AW-1:6], tile_o[3:0], tile_o[5:4]};

  // --------------------------------------------------------------------------
  // PROM decode
  // --------------------------------------------------------------------------
  logic          prom_hit;
  logic [AW-1:0] prom_idx;

  assign prom_hit = ioctl_addr >= PROM_START;
  assign prom_idx = (ioctl_addr - PROM_START) >> 8;

  always_comb begin
    prom_we_d   = '0;
    prom_addr_d = prom_addr_q;
    prom_data_d = prom_data_q;
    if (wr_acc && prom_hit) begin
      for (int i = 0; i < PW; i++) begin
        prom_we_d[i] = (prom_idx == AW'(i));
      end
      if (prom_idx < AW'(PW)) begin
        prom_addr_d = ioctl_addr[7:0];
        prom_data_d = ioctl_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Byte pairing and FIFO push generation
  //   push_a: flush of a held even byte (always older, so queued first)
  //   push_b: word produced by the current byte
  // --------------------------------------------------------------------------
  word_t push_a;
  word_t push_b;
  logic  push_a_v;
  logic  push_b_v;
  word_t flush_word;
  logic  pair_ok;

  assign flush_word = '{addr: pend_word_q, data: {pend_byte_q, pend_byte_q}, mask: 2'b10};
  // An odd byte completes the pair only if it directly follows the held byte
  // inside the same region.
  assign pair_ok    = pend_v_q && (ioctl_addr == pend_addr_q + AW'(1)) &&
                      (reg_sel == pend_reg_q) && off[0];

  always_comb begin
    push_a      = flush_word;
    push_a_v    = 1'b0;
    push_b      = '{addr: '0, data: {ioctl_data, ioctl_data}, mask: 2'b11};
    push_b_v    = 1'b0;
    pend_v_d    = pend_v_q;
    pend_word_d = pend_word_q;
    pend_addr_d = pend_addr_q;
    pend_byte_d = pend_byte_q;
    pend_reg_d  = pend_reg_q;

    if (dl_fall) begin
      push_a_v = pend_v_q;
      pend_v_d = 1'b0;
    end else if (wr_acc) begin
      if (prom_hit || !reg_hit) begin
        // Not a LIN continuation: any held byte goes out alone.
        push_a_v = pend_v_q;
        pend_v_d = 1'b0;
      end else begin
        case (sel_mode)
          MODE_CHR: begin
            push_a_v    = pend_v_q;
            pend_v_d    = 1'b0;
            push_b_v    = 1'b1;
            push_b.addr = chr_word;
            push_b.mask = off[3] ? 2'b01 : 2'b10;
          end
          MODE_TILE: begin
            push_a_v    = pend_v_q;
            pend_v_d    = 1'b0;
            push_b_v    = 1'b1;
            push_b.addr = tile_word;
            push_b.mask = tile_top ? 2'b01 : 2'b10;
          end
          default: begin
            if (pair_ok) begin
              push_b_v    = 1'b1;
              push_b.addr = lin_word;
              push_b.data = {ioctl_data, pend_byte_q};
              push_b.mask = 2'b00;
              pend_v_d    = 1'b0;
            end else begin
              push_a_v = pend_v_q;
              if (!off[0]) begin
                pend_v_d    = 1'b1;
                pend_word_d = lin_word;
                pend_addr_d = ioctl_addr;
                pend_byte_d = ioctl_data;
                pend_reg_d  = reg_sel;
              end else begin
                pend_v_d    = 1'b0;
                push_b_v    = 1'b1;
                push_b.addr = lin_word;
                push_b.mask = 2'b01;
              end
            end
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // 2-entry FIFO. Pop is applied first so a full FIFO that is draining this
  // cycle can still take a word. Words that find no slot are dropped.
  // --------------------------------------------------------------------------
  logic pop;
  logic drop;

  assign pop = (cnt_q != 2'd0) & prog_rdy;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    drop    = 1'b0;

    if (pop) begin
      slot0_d = slot1_q;
      cnt_d   = cnt_q - 2'd1;
    end

    if (push_a_v) begin
      if (cnt_d == 2'd0) begin
        slot0_d = push_a;
        cnt_d   = 2'd1;
      end else if (cnt_d == 2'd1) begin
        slot1_d = push_a;
        cnt_d   = 2'd2;
      end else begin
        drop = 1'b1;
      end
    end

    if (push_b_v) begin
      if (cnt_d == 2'd0) begin
        slot0_d = push_b;
        cnt_d   = 2'd1;
      end else if (cnt_d == 2'd1) begin
        slot1_d = push_b;
        cnt_d   = 2'd2;
      end else begin
        drop = 1'b1;
      end
    end

    // A drop in the very cycle the window reopens still counts.
    ovf_d = ovf_q;
    if (dl_rise) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_q        <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_word_q <= '0;
      pend_addr_q <= '0;
      pend_byte_q <= '0;
      pend_reg_q  <= '0;
      // NOTE: the FIFO slots are plain flops and are reset with everything
      // else, so no X can reach the output muxes after a mid-download reset.
      slot0_q     <= '{addr: '0, data: '0, mask: 2'b11};
      slot1_q     <= '{addr: '0, data: '0, mask: 2'b11};
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      prom_we_q   <= '0;
      prom_addr_q <= '0;
      prom_data_q <= '0;
    end else begin
      dl_q        <= dl_d;
      pend_v_q    <= pend_v_d;
      pend_word_q <= pend_word_d;
      pend_addr_q <= pend_addr_d;
      pend_byte_q <= pend_byte_d;
      pend_reg_q  <= pend_reg_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      prom_we_q   <= prom_we_d;
      prom_addr_q <= prom_addr_d;
      prom_data_q <= prom_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The head is masked off while empty so idle outputs read as reset.
  // --------------------------------------------------------------------------
  assign prog_we    = (cnt_q != 2'd0);
  assign prog_addr  = prog_we ? slot0_q.addr : '0;
  assign prog_data  = prog_we ? slot0_q.data : '0;
  assign prog_mask  = prog_we ? slot0_q.mask : 2'b11;
  assign prom_we    = prom_we_q;
  assign prom_addr  = prom_addr_q;
  assign prom_data  = prom_data_q;
  assign overflow   = ovf_q;
  assign dwnld_busy = downloading | prog_we | pend_v_q;

endmodule
